hw_control_unit: RTL

- Hardwired control sequencer that drives the datapath control strobes, replacing hand-sequenced bench stimulus.
- Moore FSM: fetch (T0-T2), then execute (T3-T6) decoded from IR fields.
- Sits beside the datapath; consumes the IR, Mem_ready and Run/Stop controls; produces every register in/out strobe, Read, IncPC and the ALU opcode.

---
 rtl/hw_control_unit_pkg.sv | 67 ++++++
 rtl/hw_control_unit_if.sv | 52 +++++
 rtl/hw_control_unit_reg_onehot_dec.sv | 19 +
 rtl/hw_control_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hw_control_unit_pkg.sv
// Shared definitions for the hardwired control sequencer: opcode values,
// sequencer state encodings, IR field positions and small opcode classifiers.
// The datapath and the benches import this same package.
package hw_control_unit_pkg;

    // Default sizing of the register file and the ALU opcode field
    localparam int NREG_DEF    = 16;
    localparam int OPW_DEF     = 5;

    // IR field layout: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]
    localparam int OP_MSB      = 31;
    localparam int RA_MSB      = 26;
    localparam int RB_MSB      = 22;
    localparam int RC_MSB      = 18;
    localparam int REG_FIELD_W = 4;

    // Opcode encodings understood by the sequencer
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Fetch is T0-T2, execute is T3-T6; IDLE only follows reset
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    // True for every opcode the sequencer knows how to execute
    function automatic logic op_is_legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_MUL, OP_DIV, OP_NEG, OP_NOT,
            OP_NOP, OP_HALT: op_is_legal = 1'b1;
            default:         op_is_legal = 1'b0;
        endcase
    endfunction

    // Multiply and divide produce a 64-bit result and need the extra T6 step
    function automatic logic op_is_muldiv(input logic [4:0] op);
        op_is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Single-operand ops take their operand from Rb in both T3 and T4
    function automatic logic op_is_unary(input logic [4:0] op);
        op_is_unary = (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/hw_control_unit_if.sv
// Control bus between the sequencer (master) and the datapath (slave):
// IR, memory handshake and run controls in, every datapath strobe out.
interface hw_control_unit_if #(
    parameter int NREG = hw_control_unit_pkg::NREG_DEF,
    parameter int OPW  = hw_control_unit_pkg::OPW_DEF
);

    logic [31:0]     IR;
    logic            Mem_ready;
    logic            Start;
    logic            Stop;

    logic            PCout;
    logic            Zhighout;
    logic            Zlowout;
    logic            MDRout;
    logic            HIout;
    logic            LOout;

    logic            MARin;
    logic            Zin;
    logic            PCin;
    logic            MDRin;
    logic            IRin;
    logic            Yin;
    logic            HIin;
    logic            LOin;

    logic            IncPC;
    logic            Read;

    logic [NREG-1:0] Rin;
    logic [NREG-1:0] Rout;
    logic [OPW-1:0]  opcode;
    logic            Run;
    logic            Illegal;

    modport master (
        input  IR, Mem_ready, Start, Stop,
        output PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
        output IncPC, Read, Rin, Rout, opcode, Run, Illegal
    );

    modport slave (
        output IR, Mem_ready, Start, Stop,
        input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
        input  IncPC, Read, Rin, Rout, opcode, Run, Illegal
    );

endinterface

// File: rtl/hw_control_unit_reg_onehot_dec.sv
// reg_onehot_dec: turns a 4-bit register number plus an enable into a
// one-hot select across the register file (all zero when disabled).
module hw_control_unit_reg_onehot_dec #(
    parameter int NREG = 16
) (
    input  logic [3:0]      sel,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    // Raise exactly the selected line; register numbers beyond NREG select nothing
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            onehot[i] = en && (int'(sel) == i);
        end
    end

endmodule

// File: rtl/hw_control_unit.sv
// Hardwired Moore control sequencer: fetch in T0-T2, execute in T3-T6,
// decoded from the IR. All strobes are a pure decode of state plus IR.
// Optional feature macro HWCU_ILLEGAL_TRAP_EN: when defined an illegal opcode
// sets a sticky Illegal flag and halts; otherwise it behaves as a nop.
module hw_control_unit #(
    parameter int NREG = hw_control_unit_pkg::NREG_DEF,
    parameter int OPW  = hw_control_unit_pkg::OPW_DEF
) (
    input  logic              Clock,
    input  logic              clear_n,
    hw_control_unit_if.master bus
);

    import hw_control_unit_pkg::*;

    state_t                 state;
    state_t                 next_state;
    state_t                 boundary;
    logic                   stop_pend;
    logic [OPW-1:0]         op;
    logic [REG_FIELD_W-1:0] ra;
    logic [REG_FIELD_W-1:0] rb;
    logic [REG_FIELD_W-1:0] rc;
    logic                   op_legal;
    logic                   rin_en;
    logic                   rout_en;
    logic [REG_FIELD_W-1:0] rin_sel;
    logic [REG_FIELD_W-1:0] rout_sel;
    logic                   unused_ir;

    assign op        = bus.IR[OP_MSB -: OPW];
    assign ra        = bus.IR[RA_MSB -: REG_FIELD_W];
    assign rb        = bus.IR[RB_MSB -: REG_FIELD_W];
    assign rc        = bus.IR[RC_MSB -: REG_FIELD_W];
    assign op_legal  = op_is_legal(op);
    assign unused_ir = &{1'b0, bus.IR[RC_MSB-REG_FIELD_W:0]};

    // Every instruction boundary goes to HALT if a stop is live now or pending
    assign boundary = (bus.Stop || stop_pend) ? ST_HALT : ST_T0;

    // State register; reset aborts any instruction and parks in IDLE
    always_ff @(posedge Clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Remember a mid-instruction Stop until the resuming Start clears it
    always_ff @(posedge Clock or negedge clear_n) begin
        if (!clear_n) begin
            stop_pend <= 1'b0;
        end else if ((state == ST_HALT) && bus.Start && !bus.Stop) begin
            stop_pend <= 1'b0;
        end else if (bus.Stop && (state != ST_IDLE)) begin
            stop_pend <= 1'b1;
        end
    end

`ifdef HWCU_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky trap flag: set when an unknown opcode reaches decode, held until reset
    always_ff @(posedge Clock or negedge clear_n) begin
        if (!clear_n) begin
            illegal_q <= 1'b0;
        end else if ((state == ST_T2) && !op_legal) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.Illegal = illegal_q;
`else
    assign bus.Illegal = 1'b0;
`endif

    // Next-state and strobe decode; everything idles at zero unless a state asks
    always_comb begin
        next_state   = state;
        bus.PCout    = 1'b0;
        bus.Zhighout = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.MDRout   = 1'b0;
        bus.HIout    = 1'b0;
        bus.LOout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.Zin      = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.opcode   = '0;
        bus.Run      = (state != ST_IDLE) && (state != ST_HALT);
        rin_en       = 1'b0;
        rin_sel      = ra;
        rout_en      = 1'b0;
        rout_sel     = rb;

        case (state)
            ST_IDLE: begin
                next_state = ST_T0;
            end
            ST_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.PCin   = 1'b1;
                next_state = ST_T1;
            end
            ST_T1: begin
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
                if (bus.Mem_ready) begin
                    next_state = ST_T2;
                end
            end
            ST_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                if (op == OP_HALT) begin
                    next_state = ST_HALT;
                end else if (op == OP_NOP) begin
                    next_state = boundary;
                end else if (!op_legal) begin
`ifdef HWCU_ILLEGAL_TRAP_EN
                    next_state = ST_HALT;
`else
                    next_state = boundary;
`endif
                end else begin
                    next_state = ST_T3;
                end
            end
            ST_T3: begin
                rout_en    = 1'b1;
                rout_sel   = rb;
                bus.Yin    = 1'b1;
                next_state = ST_T4;
            end
            ST_T4: begin
                rout_en    = 1'b1;
                rout_sel   = op_is_unary(op) ? rb : rc;
                bus.opcode = op;
                bus.Zin    = 1'b1;
                next_state = ST_T5;
            end
            ST_T5: begin
                bus.Zlowout = 1'b1;
                if (op_is_muldiv(op)) begin
                    bus.LOin   = 1'b1;
                    next_state = ST_T6;
                end else begin
                    rin_en     = 1'b1;
                    rin_sel    = ra;
                    next_state = boundary;
                end
            end
            ST_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                next_state   = boundary;
            end
            ST_HALT: begin
                if (bus.Start && !bus.Stop) begin
                    next_state = ST_T0;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    hw_control_unit_reg_onehot_dec #(.NREG(NREG)) u_rin_dec (
        .sel    (rin_sel),
        .en     (rin_en),
        .onehot (bus.Rin)
    );

    hw_control_unit_reg_onehot_dec #(.NREG(NREG)) u_rout_dec (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (bus.Rout)
    );

endmodule
